// File: rtl/axi5_arbiter_if.sv
// AXI5 channel bundle shared by the arbiter's upstream and downstream ports.
// Carries the AW, W, B, AR and R channels with the payload fields the
// arbiter steers. Optional build macro of the arbiter: AXI5_ARB_FIXED_PRIO_EN.
interface axi5 #(
    parameter int alen = 32,
    parameter int xlen = 32,
    parameter int ilen = 2
) ();
    logic [ilen-1:0]   aw_id;
    logic [alen-1:0]   aw_addr;
    logic [7:0]        aw_len;
    logic              aw_valid;
    logic              aw_ready;

    logic [xlen-1:0]   w_data;
    logic [xlen/8-1:0] w_strb;
    logic              w_last;
    logic              w_valid;
    logic              w_ready;

    logic [ilen-1:0]   b_id;
    logic [1:0]        b_resp;
    logic              b_valid;
    logic              b_ready;

    logic [ilen-1:0]   ar_id;
    logic [alen-1:0]   ar_addr;
    logic [7:0]        ar_len;
    logic              ar_valid;
    logic              ar_ready;

    logic [ilen-1:0]   r_id;
    logic [xlen-1:0]   r_data;
    logic [1:0]        r_resp;
    logic              r_last;
    logic              r_valid;
    logic              r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_valid, input aw_ready,
        output w_data, w_strb, w_last, w_valid, input w_ready,
        input b_id, b_resp, b_valid, output b_ready,
        output ar_id, ar_addr, ar_len, ar_valid, input ar_ready,
        input r_id, r_data, r_resp, r_last, r_valid, output r_ready
    );

    modport slave (
        input aw_id, aw_addr, aw_len, aw_valid, output aw_ready,
        input w_data, w_strb, w_last, w_valid, output w_ready,
        output b_id, b_resp, b_valid, input b_ready,
        input ar_id, ar_addr, ar_len, ar_valid, output ar_ready,
        output r_id, r_data, r_resp, r_last, r_valid, input r_ready
    );
endinterface

// File: rtl/axi5_arbiter.sv
// N-to-1 AXI5 arbiter: independent write and read paths, each holding one
// granted master for a whole transaction and steering its channels straight
// through to the shared downstream slave without buffering.
// Build macro AXI5_ARB_FIXED_PRIO_EN: lowest-index requester always wins
// (pointers tied to 0); otherwise grants rotate round-robin.
module axi5_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int alen        = 32,
    parameter int xlen        = 32,
    parameter int ilen        = 2
) (
    input logic clk,
    input logic rst_n,
    axi5.slave  up [NUM_MASTERS],
    axi5.master dn
);
    localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SW = xlen / 8;
`ifdef AXI5_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

    wr_state_t wr_state_q, wr_state_d;
    rd_state_t rd_state_q, rd_state_d;
    logic [PW-1:0] wr_grant_q, wr_grant_d, wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_grant_q, rd_grant_d, rd_ptr_q, rd_ptr_d;

    logic [ilen-1:0] aw_id_i [NUM_MASTERS];
    logic [alen-1:0] aw_addr_i [NUM_MASTERS];
    logic [7:0]      aw_len_i [NUM_MASTERS];
    logic [xlen-1:0] w_data_i [NUM_MASTERS];
    logic [SW-1:0]   w_strb_i [NUM_MASTERS];
    logic [ilen-1:0] ar_id_i [NUM_MASTERS];
    logic [alen-1:0] ar_addr_i [NUM_MASTERS];
    logic [7:0]      ar_len_i [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] aw_valid_i, w_valid_i, w_last_i, b_ready_i, ar_valid_i, r_ready_i;

    logic [ilen-1:0] b_id_o [NUM_MASTERS];
    logic [1:0]      b_resp_o [NUM_MASTERS];
    logic [ilen-1:0] r_id_o [NUM_MASTERS];
    logic [xlen-1:0] r_data_o [NUM_MASTERS];
    logic [1:0]      r_resp_o [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] aw_ready_o, w_ready_o, b_valid_o, ar_ready_o, r_valid_o, r_last_o;

    // First requester at or after base, scanning upward with wrap
    function automatic logic [PW-1:0] pick_next(input logic [NUM_MASTERS-1:0] req,
                                                input logic [PW-1:0] base);
        logic [PW-1:0] sel;
        sel = base;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (req[(int'(base) + k) % NUM_MASTERS]) begin
                sel = PW'((int'(base) + k) % NUM_MASTERS);
            end
        end
        return sel;
    endfunction

    // Pointer value after master g finishes; stays at 0 under fixed priority
    function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] g);
        if (FIXED_PRIO) return '0;
        return (int'(g) == NUM_MASTERS - 1) ? '0 : g + 1'b1;
    endfunction

    // Flatten the interface array so the grant index can select a master
    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_up
        assign aw_id_i[i]    = up[i].aw_id;
        assign aw_addr_i[i]  = up[i].aw_addr;
        assign aw_len_i[i]   = up[i].aw_len;
        assign aw_valid_i[i] = up[i].aw_valid;
        assign w_data_i[i]   = up[i].w_data;
        assign w_strb_i[i]   = up[i].w_strb;
        assign w_last_i[i]   = up[i].w_last;
        assign w_valid_i[i]  = up[i].w_valid;
        assign b_ready_i[i]  = up[i].b_ready;
        assign ar_id_i[i]    = up[i].ar_id;
        assign ar_addr_i[i]  = up[i].ar_addr;
        assign ar_len_i[i]   = up[i].ar_len;
        assign ar_valid_i[i] = up[i].ar_valid;
        assign r_ready_i[i]  = up[i].r_ready;
        assign up[i].aw_ready = aw_ready_o[i];
        assign up[i].w_ready  = w_ready_o[i];
        assign up[i].b_id     = b_id_o[i];
        assign up[i].b_resp   = b_resp_o[i];
        assign up[i].b_valid  = b_valid_o[i];
        assign up[i].ar_ready = ar_ready_o[i];
        assign up[i].r_id     = r_id_o[i];
        assign up[i].r_data   = r_data_o[i];
        assign up[i].r_resp   = r_resp_o[i];
        assign up[i].r_last   = r_last_o[i];
        assign up[i].r_valid  = r_valid_o[i];
    end

    // Write path: arbitrate on AW, then steer AW, W and B of the granted master
    always_comb begin
        wr_state_d = wr_state_q;
        wr_grant_d = wr_grant_q;
        wr_ptr_d   = wr_ptr_q;
        aw_ready_o = '0;
        w_ready_o  = '0;
        b_valid_o  = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            b_id_o[k]   = '0;
            b_resp_o[k] = '0;
        end
        dn.aw_id    = '0;
        dn.aw_addr  = '0;
        dn.aw_len   = '0;
        dn.aw_valid = 1'b0;
        dn.w_data   = '0;
        dn.w_strb   = '0;
        dn.w_last   = 1'b0;
        dn.w_valid  = 1'b0;
        dn.b_ready  = 1'b0;
        unique case (wr_state_q)
            W_IDLE: begin
                if (|aw_valid_i) begin
                    wr_grant_d = pick_next(aw_valid_i, wr_ptr_q);
                    wr_state_d = W_ADDR;
                end
            end
            W_ADDR: begin
                dn.aw_id    = aw_id_i[wr_grant_q];
                dn.aw_addr  = aw_addr_i[wr_grant_q];
                dn.aw_len   = aw_len_i[wr_grant_q];
                dn.aw_valid = aw_valid_i[wr_grant_q];
                aw_ready_o[wr_grant_q] = dn.aw_ready;
                if (aw_valid_i[wr_grant_q] && dn.aw_ready) wr_state_d = W_DATA;
            end
            W_DATA: begin
                dn.w_data  = w_data_i[wr_grant_q];
                dn.w_strb  = w_strb_i[wr_grant_q];
                dn.w_last  = w_last_i[wr_grant_q];
                dn.w_valid = w_valid_i[wr_grant_q];
                w_ready_o[wr_grant_q] = dn.w_ready;
                if (w_valid_i[wr_grant_q] && dn.w_ready && w_last_i[wr_grant_q]) begin
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                b_id_o[wr_grant_q]    = dn.b_id;
                b_resp_o[wr_grant_q]  = dn.b_resp;
                b_valid_o[wr_grant_q] = dn.b_valid;
                dn.b_ready = b_ready_i[wr_grant_q];
                if (dn.b_valid && b_ready_i[wr_grant_q]) begin
                    wr_state_d = W_IDLE;
                    wr_ptr_d   = ptr_after(wr_grant_q);
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Read path: arbitrate on AR, then steer AR and R of the granted master
    always_comb begin
        rd_state_d = rd_state_q;
        rd_grant_d = rd_grant_q;
        rd_ptr_d   = rd_ptr_q;
        ar_ready_o = '0;
        r_valid_o  = '0;
        r_last_o   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            r_id_o[k]   = '0;
            r_data_o[k] = '0;
            r_resp_o[k] = '0;
        end
        dn.ar_id    = '0;
        dn.ar_addr  = '0;
        dn.ar_len   = '0;
        dn.ar_valid = 1'b0;
        dn.r_ready  = 1'b0;
        unique case (rd_state_q)
            R_IDLE: begin
                if (|ar_valid_i) begin
                    rd_grant_d = pick_next(ar_valid_i, rd_ptr_q);
                    rd_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                dn.ar_id    = ar_id_i[rd_grant_q];
                dn.ar_addr  = ar_addr_i[rd_grant_q];
                dn.ar_len   = ar_len_i[rd_grant_q];
                dn.ar_valid = ar_valid_i[rd_grant_q];
                ar_ready_o[rd_grant_q] = dn.ar_ready;
                if (ar_valid_i[rd_grant_q] && dn.ar_ready) rd_state_d = R_DATA;
            end
            R_DATA: begin
                r_id_o[rd_grant_q]    = dn.r_id;
                r_data_o[rd_grant_q]  = dn.r_data;
                r_resp_o[rd_grant_q]  = dn.r_resp;
                r_last_o[rd_grant_q]  = dn.r_last;
                r_valid_o[rd_grant_q] = dn.r_valid;
                dn.r_ready = r_ready_i[rd_grant_q];
                if (dn.r_valid && r_ready_i[rd_grant_q] && dn.r_last) begin
                    rd_state_d = R_IDLE;
                    rd_ptr_d   = ptr_after(rd_grant_q);
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // State, grant and pointer registers for both paths
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= W_IDLE;
            wr_grant_q <= '0;
            wr_ptr_q   <= '0;
            rd_state_q <= R_IDLE;
            rd_grant_q <= '0;
            rd_ptr_q   <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_grant_q <= wr_grant_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_state_q <= rd_state_d;
            rd_grant_q <= rd_grant_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end
endmodule

// File: tb/tb_axi5_arbiter.sv
// Directed testbench for axi5_arbiter with two upstream masters.
// Build with AXI5_ARB_FIXED_PRIO_EN defined to check the fixed-priority grant order.
module tb_axi5_arbiter;
    localparam int NM = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    // Clock generation, 10 time-unit period
    always #5 clk = ~clk;

    axi5 #(.alen(32), .xlen(32), .ilen(2)) up_if [NM] ();
    axi5 #(.alen(32), .xlen(32), .ilen(2)) dn_if ();

    axi5_arbiter #(.NUM_MASTERS(NM), .alen(32), .xlen(32), .ilen(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .up    (up_if),
        .dn    (dn_if)
    );

    logic [NM-1:0] m_aw_valid, m_w_valid, m_w_last, m_b_ready, m_ar_valid, m_r_ready;
    logic [1:0]    m_aw_id [NM];
    logic [31:0]   m_aw_addr [NM];
    logic [7:0]    m_aw_len [NM];
    logic [31:0]   m_w_data [NM];
    logic [1:0]    m_ar_id [NM];
    logic [31:0]   m_ar_addr [NM];
    logic [7:0]    m_ar_len [NM];

    logic [NM-1:0] s_aw_ready, s_w_ready, s_b_valid, s_ar_ready, s_r_valid, s_r_last;
    logic [1:0]    s_b_id [NM];
    logic [31:0]   s_r_data [NM];

    logic        d_aw_ready, d_w_ready, d_b_valid, d_ar_ready, d_r_valid, d_r_last;
    logic [1:0]  d_b_id, d_r_id;
    logic [31:0] d_r_data;

    for (genvar i = 0; i < NM; i++) begin : g_map
        assign up_if[i].aw_id    = m_aw_id[i];
        assign up_if[i].aw_addr  = m_aw_addr[i];
        assign up_if[i].aw_len   = m_aw_len[i];
        assign up_if[i].aw_valid = m_aw_valid[i];
        assign up_if[i].w_data   = m_w_data[i];
        assign up_if[i].w_strb   = 4'hF;
        assign up_if[i].w_last   = m_w_last[i];
        assign up_if[i].w_valid  = m_w_valid[i];
        assign up_if[i].b_ready  = m_b_ready[i];
        assign up_if[i].ar_id    = m_ar_id[i];
        assign up_if[i].ar_addr  = m_ar_addr[i];
        assign up_if[i].ar_len   = m_ar_len[i];
        assign up_if[i].ar_valid = m_ar_valid[i];
        assign up_if[i].r_ready  = m_r_ready[i];
        assign s_aw_ready[i] = up_if[i].aw_ready;
        assign s_w_ready[i]  = up_if[i].w_ready;
        assign s_b_valid[i]  = up_if[i].b_valid;
        assign s_b_id[i]     = up_if[i].b_id;
        assign s_ar_ready[i] = up_if[i].ar_ready;
        assign s_r_valid[i]  = up_if[i].r_valid;
        assign s_r_last[i]   = up_if[i].r_last;
        assign s_r_data[i]   = up_if[i].r_data;
    end

    assign dn_if.aw_ready = d_aw_ready;
    assign dn_if.w_ready  = d_w_ready;
    assign dn_if.b_id     = d_b_id;
    assign dn_if.b_resp   = 2'b00;
    assign dn_if.b_valid  = d_b_valid;
    assign dn_if.ar_ready = d_ar_ready;
    assign dn_if.r_id     = d_r_id;
    assign dn_if.r_data   = d_r_data;
    assign dn_if.r_resp   = 2'b00;
    assign dn_if.r_last   = d_r_last;
    assign dn_if.r_valid  = d_r_valid;

    int dn_wbeats = 0;
    int up1_rbeats = 0;

    // Beat counters: W beats accepted downstream, R beats accepted by master 1
    always @(posedge clk) begin
        if (dn_if.w_valid && dn_if.w_ready) dn_wbeats <= dn_wbeats + 1;
        if (s_r_valid[1] && m_r_ready[1]) up1_rbeats <= up1_rbeats + 1;
    end

    // Safety net so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive every bench-owned input to its idle value
    task automatic applyStimulus;
        m_aw_valid = '0; m_w_valid = '0; m_w_last = '0; m_b_ready = '0;
        m_ar_valid = '0; m_r_ready = '0;
        for (int i = 0; i < NM; i++) begin
            m_aw_id[i] = 2'(i + 1); m_aw_addr[i] = 32'h0; m_aw_len[i] = 8'h0;
            m_w_data[i] = 32'h0; m_ar_id[i] = 2'(i); m_ar_addr[i] = 32'h0; m_ar_len[i] = 8'h0;
        end
        d_aw_ready = 1'b1; d_w_ready = 1'b1; d_b_valid = 1'b0; d_b_id = 2'b00;
        d_ar_ready = 1'b1; d_r_valid = 1'b0; d_r_last = 1'b0; d_r_id = 2'b00; d_r_data = 32'h0;
    endtask

    // One complete write by master g; caller has raised the aw_valid bits
    task automatic wr_txn(input int g, input int nbeats, input int stall,
                          input logic [31:0] base, input string tag);
        int other;
        logic [1:0] id;
        other = 1 - g;
        id = m_aw_id[g];
        settle;
        checkOutput({tag, ".bubble_awvalid"}, dn_if.aw_valid, 1'b0);
        tick;
        settle;
        checkOutput({tag, ".awready_granted"}, s_aw_ready[g], 1'b1);
        checkOutput({tag, ".awready_other"}, s_aw_ready[other], 1'b0);
        checkOutput({tag, ".aw_addr"}, dn_if.aw_addr, m_aw_addr[g]);
        checkOutput({tag, ".aw_id"}, dn_if.aw_id, id);
        checkOutput({tag, ".early_wvalid"}, dn_if.w_valid, 1'b0);
        checkOutput({tag, ".early_wready"}, s_w_ready[g], 1'b0);
        tick;
        m_aw_valid = '0;
        for (int b = 0; b < nbeats; b++) begin
            m_w_valid[g] = 1'b1;
            m_w_data[g]  = base + 32'(b);
            m_w_last[g]  = (b == nbeats - 1);
            if (b == 1) begin
                for (int s = 0; s < stall; s++) begin
                    d_w_ready = 1'b0;
                    settle;
                    checkOutput({tag, ".stall_wready"}, s_w_ready[g], 1'b0);
                    checkOutput({tag, ".stall_wvalid"}, dn_if.w_valid, 1'b1);
                    tick;
                end
            end
            d_w_ready = 1'b1;
            settle;
            checkOutput({tag, ".w_data"}, dn_if.w_data, base + 32'(b));
            checkOutput({tag, ".w_last"}, dn_if.w_last, (b == nbeats - 1));
            checkOutput({tag, ".wready_granted"}, s_w_ready[g], 1'b1);
            tick;
        end
        m_w_valid = '0;
        m_w_last  = '0;
        d_b_valid = 1'b1;
        d_b_id    = id;
        m_b_ready[g] = 1'b1;
        settle;
        checkOutput({tag, ".bvalid_granted"}, s_b_valid[g], 1'b1);
        checkOutput({tag, ".bvalid_other"}, s_b_valid[other], 1'b0);
        checkOutput({tag, ".b_id"}, s_b_id[g], id);
        checkOutput({tag, ".dn_bready"}, dn_if.b_ready, 1'b1);
        tick;
        d_b_valid = 1'b0;
        m_b_ready = '0;
    endtask

    int cont_order [4];
    int grant_after_single;
    int w0;
    int r0;

    // Directed sequence
    initial begin
`ifdef AXI5_ARB_FIXED_PRIO_EN
        cont_order = '{0, 0, 0, 0};
        grant_after_single = 0;
`else
        cont_order = '{0, 1, 0, 1};
        grant_after_single = 1;
`endif
        applyStimulus;
        rst_n = 1'b0;
        m_aw_valid = 2'b11; m_aw_addr[0] = 32'hDEAD; m_ar_valid = 2'b11; m_w_valid = 2'b11;
        tick;
        tick;
        settle;
        checkOutput("reset.up_awready", s_aw_ready, 2'b00);
        checkOutput("reset.up_wready", s_w_ready, 2'b00);
        checkOutput("reset.up_bvalid", s_b_valid, 2'b00);
        checkOutput("reset.up_arready", s_ar_ready, 2'b00);
        checkOutput("reset.up_rvalid", s_r_valid, 2'b00);
        checkOutput("reset.dn_awvalid", dn_if.aw_valid, 1'b0);
        checkOutput("reset.dn_aw_addr", dn_if.aw_addr, 32'h0);
        checkOutput("reset.dn_wvalid", dn_if.w_valid, 1'b0);
        checkOutput("reset.dn_arvalid", dn_if.ar_valid, 1'b0);
        checkOutput("reset.dn_bready", dn_if.b_ready, 1'b0);
        checkOutput("reset.dn_rready", dn_if.r_ready, 1'b0);
        applyStimulus;
        rst_n = 1'b1;
        tick;

        m_aw_addr[0] = 32'h0000_0200;
        m_aw_addr[1] = 32'h0000_1200;
        for (int i = 0; i < 4; i++) begin
            m_aw_valid = 2'b11;
            wr_txn(cont_order[i], 1, 0, 32'h1000 + 32'(i * 16), $sformatf("cont%0d", i));
        end

        m_aw_id[0] = 2'd2; m_aw_addr[0] = 32'h100; m_aw_len[0] = 8'd3;
        m_aw_valid = 2'b01;
        w0 = dn_wbeats;
        wr_txn(0, 4, 5, 32'h0000_00A0, "single");
        checkOutput("single.beat_count", 64'(dn_wbeats - w0), 64'd4);

        m_aw_len[0] = 8'd0;
        m_aw_valid = 2'b11;
        wr_txn(grant_after_single, 1, 0, 32'h0000_0B00, "ptr");

        m_w_valid[1] = 1'b1; m_w_data[1] = 32'h55; m_w_last[1] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle;
            checkOutput("wfirst.up1_wready", s_w_ready[1], 1'b0);
            checkOutput("wfirst.dn_wvalid", dn_if.w_valid, 1'b0);
            tick;
        end
        m_aw_valid = 2'b10;
        wr_txn(1, 1, 0, 32'h0000_0300, "wfirst");

        m_aw_addr[0] = 32'h140; m_aw_len[0] = 8'd3; m_aw_valid = 2'b01;
        m_ar_addr[1] = 32'h800; m_ar_len[1] = 8'd7; m_ar_id[1] = 2'd1; m_ar_valid = 2'b10;
        settle;
        checkOutput("conc.bubble_arvalid", dn_if.ar_valid, 1'b0);
        tick;
        settle;
        checkOutput("conc.arready_up1", s_ar_ready[1], 1'b1);
        checkOutput("conc.arready_up0", s_ar_ready[0], 1'b0);
        checkOutput("conc.ar_addr", dn_if.ar_addr, 32'h800);
        checkOutput("conc.awready_up0", s_aw_ready[0], 1'b1);
        tick;
        m_aw_valid = '0;
        m_ar_valid = '0;
        r0 = up1_rbeats;
        w0 = dn_wbeats;
        for (int c = 0; c < 16; c++) begin
            d_r_valid = 1'b1;
            d_r_id    = 2'd1;
            d_r_data  = 32'h200 + 32'(c / 2);
            d_r_last  = (c / 2 == 7);
            m_r_ready[1] = c[0];
            if (c < 4) begin
                m_w_valid[0] = 1'b1; m_w_data[0] = 32'h400 + 32'(c); m_w_last[0] = (c == 3);
            end else begin
                m_w_valid[0] = 1'b0; m_w_last[0] = 1'b0;
            end
            d_b_valid = (c == 4);
            d_b_id    = 2'd2;
            m_b_ready[0] = (c == 4);
            settle;
            checkOutput("conc.dn_rready", dn_if.r_ready, c[0]);
            checkOutput("conc.up1_rdata", s_r_data[1], 32'h200 + 32'(c / 2));
            checkOutput("conc.up1_rlast", s_r_last[1], (c / 2 == 7));
            checkOutput("conc.up0_rvalid", s_r_valid[0], 1'b0);
            if (c < 4) checkOutput("conc.w_data", dn_if.w_data, 32'h400 + 32'(c));
            if (c == 4) begin
                checkOutput("conc.up0_bvalid", s_b_valid[0], 1'b1);
                checkOutput("conc.up1_bvalid", s_b_valid[1], 1'b0);
            end
            tick;
        end
        d_r_valid = 1'b0; d_r_last = 1'b0; m_r_ready = '0; d_b_valid = 1'b0; m_b_ready = '0;
        settle;
        checkOutput("conc.r_beats", 64'(up1_rbeats - r0), 64'd8);
        checkOutput("conc.w_beats", 64'(dn_wbeats - w0), 64'd4);
        checkOutput("conc.rvalid_after", s_r_valid[1], 1'b0);

        m_aw_addr[1] = 32'h1200; m_aw_len[1] = 8'd3; m_aw_valid = 2'b10;
        tick;
        tick;
        m_aw_valid = '0;
        m_w_valid[1] = 1'b1; m_w_data[1] = 32'h700; m_w_last[1] = 1'b0;
        tick;
        m_w_data[1] = 32'h701;
        settle;
        checkOutput("midrst.pre_wvalid", dn_if.w_valid, 1'b1);
        rst_n = 1'b0;
        settle;
        checkOutput("midrst.dn_wvalid", dn_if.w_valid, 1'b0);
        checkOutput("midrst.up1_wready", s_w_ready[1], 1'b0);
        checkOutput("midrst.up_awready", s_aw_ready, 2'b00);
        checkOutput("midrst.up_bvalid", s_b_valid, 2'b00);
        applyStimulus;
        tick;
        rst_n = 1'b1;
        tick;
        m_aw_addr[1] = 32'h1300;
        m_aw_valid = 2'b10;
        wr_txn(1, 1, 0, 32'h0000_0900, "postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
